data_ram_arbiter: RTL

- Shares the single write/read access port of the data RAM between two requesters: the ALU writeback/operand path and a host loader/debug port.
- ALU has fixed priority. A starvation counter guarantees host progress, and a burst limit bounds how long the host can hold the port.
- Sits between the instruction-sequencing datapath and the data RAM. It issues registered RAM commands and returns read data with a valid strobe.

---
 rtl/data_ram_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter
// Shares the data RAM access port between the ALU path and the host
// loader/debug port. ALU wins by default. A starvation counter forces a
// host grant after repeated denials, and a burst counter bounds how long
// the host keeps the port while the ALU is waiting. RAM commands are
// registered (1-cycle issue latency). Read data is registered at the end
// of the read grant cycle and flagged with a one-cycle valid strobe.
module data_ram_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4,   // 1..15
    parameter int MAX_BURST    = 3    // 1..15
) (
    input  logic              Clock,
    input  logic              Reset,        // asynchronous, active-low

    input  logic              iAluReq,
    input  logic              iAluWe,
    input  logic [ADDR_W-1:0] iAluAddr,
    input  logic [DATA_W-1:0] iAluData,
    output logic              oAluGnt,
    output logic              oAluStall,
    output logic              oAluRdValid,

    input  logic              iHostReq,
    input  logic              iHostWe,
    input  logic [ADDR_W-1:0] iHostAddr,
    input  logic [DATA_W-1:0] iHostData,
    output logic              oHostGnt,
    output logic              oHostRdValid,

    output logic              oRamWe,
    output logic [ADDR_W-1:0] oRamAddr,
    output logic [DATA_W-1:0] oRamData,
    input  logic [DATA_W-1:0] iRamRdData,
    output logic [DATA_W-1:0] oRdData
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ALU  = 2'd1,
        HOST = 2'd2
    } arbState_t;

    // Counters are 4 bits wide: both limits are bounded to 1..15.
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT - 1);
    localparam logic [3:0] BURST_MAX  = 4'(MAX_BURST);

    arbState_t  stateReg;
    arbState_t  stateNext;
    logic [3:0] starveCntReg;
    logic [3:0] starveCntNext;
    logic [3:0] burstCntReg;
    logic [3:0] burstCntNext;
    logic       hostForced;
    logic       hostBurst;

    // Winner selection, counter updates and the combinational ALU stall.
    always_comb begin
        stateNext     = IDLE;
        starveCntNext = starveCntReg;
        burstCntNext  = burstCntReg;
        hostForced    = iHostReq && (starveCntReg == STARVE_MAX);
        hostBurst     = (stateReg == HOST) && iHostReq && (burstCntReg < BURST_MAX);

        // The starvation override and an unfinished host burst both outrank the ALU.
        if (hostForced || hostBurst) begin
            stateNext = HOST;
        end else if (iAluReq) begin
            stateNext = ALU;
        end else if (iHostReq) begin
            stateNext = HOST;
        end

        // Starvation: count denied host cycles, saturating at the force point.
        if (!iHostReq || (stateNext == HOST)) begin
            starveCntNext = 4'd0;
        end else if (starveCntReg != STARVE_MAX) begin
            starveCntNext = starveCntReg + 4'd1;
        end

        // Burst: only host grants that keep a requesting ALU waiting are counted.
        // With the ALU idle the count holds, so the host is never cut off.
        if (stateNext != HOST) begin
            burstCntNext = 4'd0;
        end else if (iAluReq && (burstCntReg != 4'hF)) begin
            burstCntNext = burstCntReg + 4'd1;
        end

        oAluStall = iAluReq && (stateNext != ALU);
    end

    // Arbiter state register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Starvation and burst counters.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            starveCntReg <= 4'd0;
            burstCntReg  <= 4'd0;
        end else begin
            starveCntReg <= starveCntNext;
            burstCntReg  <= burstCntNext;
        end
    end

    // Register the winning command onto the RAM port; address/data hold when idle.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oRamWe   <= 1'b0;
            oRamAddr <= '0;
            oRamData <= '0;
            oAluGnt  <= 1'b0;
            oHostGnt <= 1'b0;
        end else begin
            oAluGnt  <= (stateNext == ALU);
            oHostGnt <= (stateNext == HOST);
            case (stateNext)
                ALU: begin
                    oRamWe   <= iAluWe;
                    oRamAddr <= iAluAddr;
                    oRamData <= iAluData;
                end
                HOST: begin
                    oRamWe   <= iHostWe;
                    oRamAddr <= iHostAddr;
                    oRamData <= iHostData;
                end
                default: begin
                    oRamWe <= 1'b0;
                end
            endcase
        end
    end

    // Capture read data at the end of a read grant and strobe the owner's valid.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oRdData      <= '0;
            oAluRdValid  <= 1'b0;
            oHostRdValid <= 1'b0;
        end else begin
            oAluRdValid  <= oAluGnt && !oRamWe;
            oHostRdValid <= oHostGnt && !oRamWe;
            if ((oAluGnt || oHostGnt) && !oRamWe) begin
                oRdData <= iRamRdData;
            end
        end
    end

endmodule
